// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared state and select encodings for the Goldschmidt divider sequencer
package gs_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        K_STEP = 3'd1,
        N_STEP = 3'd2,
        D_STEP = 3'd3,
        DONE   = 3'd4
    } gs_state_t;

    // Multiplicand select: raw operand on the first iteration, feedback register afterwards
    localparam logic [1:0] ND_RAW_D = 2'b00;
    localparam logic [1:0] ND_RAW_N = 2'b01;
    localparam logic [1:0] ND_FB_D  = 2'b10;
    localparam logic [1:0] ND_FB_N  = 2'b11;

    // K source: initial approximation on the first iteration, (2 - D) afterwards
    localparam logic KSEL_IA = 1'b0;
    localparam logic KSEL_FB = 1'b1;

endpackage

// File: rtl/gs_iter_counter.sv
// rtl/gs_iter_counter.sv - saturating refinement-iteration counter for the divider sequencer
module gs_iter_counter #(
    parameter int ITER = 3,
    parameter int W    = $clog2(ITER + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] it_o,
    output logic         last_o
);

    localparam logic [W-1:0] LAST_IT = W'(ITER - 1);

    logic [W-1:0] it_q;

    // Counter clears at the start of each divide and stops at the last iteration, never wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            it_q <= '0;
        end else if (clr_i) begin
            it_q <= '0;
        end else if (inc_i && !last_o) begin
            it_q <= it_q + 1'b1;
        end
    end

    assign it_o   = it_q;
    assign last_o = (it_q == LAST_IT);

endmodule

// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - K/N/D multiply sequencer with start/busy/done handshake
module goldschmidt_ctrl
    import gs_pkg::*;
#(
    parameter int ITER = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       flush_i,
    output logic       k_select_o,
    output logic [1:0] nd_select_o,
    output logic       k_load_o,
    output logic       n_enable_o,
    output logic       d_enable_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int W = $clog2(ITER + 1);

    if (ITER < 1) begin : g_bad_iter
        $error("goldschmidt_ctrl: ITER must be at least 1");
    end

    gs_state_t    state_q;
    logic [W-1:0] it;
    logic         it_last;
    logic         it_clr;
    logic         it_inc;

    logic         k_select_q;
    logic [1:0]   nd_select_q;
    logic         k_load_q;
    logic         n_enable_q;
    logic         d_enable_q;
    logic         busy_q;
    logic         done_q;

    // Counter restarts on every accepted start or flush and advances only on a non-final D step
    always_comb begin
        it_clr = flush_i || (((state_q == IDLE) || (state_q == DONE)) && start_i);
        it_inc = !flush_i && (state_q == D_STEP) && !it_last;
    end

    gs_iter_counter #(
        .ITER (ITER),
        .W    (W)
    ) u_iter_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (it_clr),
        .inc_i  (it_inc),
        .it_o   (it),
        .last_o (it_last)
    );

    // Moore FSM; outputs are registered alongside the state they belong to, so they
    // already reflect the entered state and its iteration in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_select_q  <= KSEL_IA;
            nd_select_q <= ND_RAW_D;
            k_load_q    <= 1'b0;
            n_enable_q  <= 1'b0;
            d_enable_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            k_select_q  <= KSEL_IA;
            nd_select_q <= ND_RAW_D;
            k_load_q    <= 1'b0;
            n_enable_q  <= 1'b0;
            d_enable_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start_i) begin
                            state_q    <= K_STEP;
                            k_select_q <= KSEL_IA;
                            k_load_q   <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    K_STEP: begin
                        // K is captured before D is overwritten, so N and D share this K
                        state_q     <= N_STEP;
                        n_enable_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        nd_select_q <= (it == '0) ? ND_RAW_N : ND_FB_N;
                    end
                    N_STEP: begin
                        state_q     <= D_STEP;
                        d_enable_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        nd_select_q <= (it == '0) ? ND_RAW_D : ND_FB_D;
                    end
                    D_STEP: begin
                        if (it_last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= K_STEP;
                            k_select_q <= KSEL_FB;
                            k_load_q   <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign k_select_o  = k_select_q;
    assign nd_select_o = nd_select_q;
    assign k_load_o    = k_load_q;
    assign n_enable_o  = n_enable_q;
    assign d_enable_o  = d_enable_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb/tb_goldschmidt_ctrl.sv - scoreboard bench for goldschmidt_ctrl with ITER=3 and ITER=1 builds
module tb_goldschmidt_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_K    = 1;
    localparam int S_N    = 2;
    localparam int S_D    = 3;
    localparam int S_DONE = 4;

    logic clk;
    logic rst_n;
    logic start3, flush3, start1, flush1;

    logic       ksel3, kld3, nen3, den3, busy3, done3;
    logic [1:0] nd3;
    logic       ksel1, kld1, nen1, den1, busy1, done1;
    logic [1:0] nd1;

    logic [7:0] obs3, obs1;
    assign obs3 = {ksel3, nd3, kld3, nen3, den3, busy3, done3};
    assign obs1 = {ksel1, nd1, kld1, nen1, den1, busy1, done1};

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    goldschmidt_ctrl #(.ITER(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .flush_i(flush3),
        .k_select_o(ksel3), .nd_select_o(nd3), .k_load_o(kld3),
        .n_enable_o(nen3), .d_enable_o(den3), .busy_o(busy3), .done_o(done3)
    );

    goldschmidt_ctrl #(.ITER(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .flush_i(flush1),
        .k_select_o(ksel1), .nd_select_o(nd1), .k_load_o(kld1),
        .n_enable_o(nen1), .d_enable_o(den1), .busy_o(busy1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector {kSelect, ndSelect, kLoad, nEnable, dEnable, busy, done}
    function automatic logic [7:0] ov(input int kind, input int it);
        logic [7:0] v;
        v = 8'h00;
        case (kind)
            S_K:    v = {(it != 0) ? 1'b1 : 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            S_N:    v = {1'b0, (it == 0) ? 2'b01 : 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            S_D:    v = {1'b0, (it == 0) ? 2'b00 : 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            S_DONE: v = 8'b0000_0001;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic push_divide(input int iters);
        for (int i = 0; i < iters; i++) begin
            exp_q.push_back(ov(S_K, i));
            exp_q.push_back(ov(S_N, i));
            exp_q.push_back(ov(S_D, i));
        end
        exp_q.push_back(ov(S_DONE, 0));
    endtask

    task automatic compare(input string tag, input logic [7:0] obs);
        logic [7:0] expv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty obs=%b", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s obs=%b exp=%b", tag, obs, expv);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int n, input bit use1);
        for (int i = 0; i < n; i++) begin
            tick();
            compare(tag, use1 ? obs1 : obs3);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start3 = 1'b0;
        flush3 = 1'b0;
        start1 = 1'b0;
        flush1 = 1'b0;

        // Reset state
        #2;
        exp_q.push_back(ov(S_IDLE, 0));
        compare("reset_outputs", obs3);
        exp_q.push_back(ov(S_IDLE, 0));
        compare("reset_outputs_iter1", obs1);
        tick();
        rst_n = 1'b1;
        exp_q.push_back(ov(S_IDLE, 0));
        run("post_reset_idle", 1, 1'b0);

        // Scenario 1: single start pulse, done in cycle 10
        push_divide(3);
        exp_q.push_back(ov(S_IDLE, 0));
        start3 = 1'b1;
        run("s1_divide", 1, 1'b0);
        start3 = 1'b0;
        run("s1_divide", 10, 1'b0);

        // Scenario 2: start held high, back-to-back divides
        push_divide(3);
        push_divide(3);
        push_divide(3);
        exp_q.push_back(ov(S_IDLE, 0));
        start3 = 1'b1;
        run("s2_b2b", 30, 1'b0);
        start3 = 1'b0;
        run("s2_b2b", 1, 1'b0);

        // Scenario 3: start pulsed while busy is ignored
        push_divide(3);
        exp_q.push_back(ov(S_IDLE, 0));
        exp_q.push_back(ov(S_IDLE, 0));
        start3 = 1'b1;
        run("s3_ignore", 1, 1'b0);
        start3 = 1'b0;
        run("s3_ignore", 3, 1'b0);
        start3 = 1'b1;
        run("s3_ignore", 2, 1'b0);
        start3 = 1'b0;
        run("s3_ignore", 6, 1'b0);

        // Scenario 4: flush in D_STEP of it=1, then a full divide
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ov(S_K, i));
            exp_q.push_back(ov(S_N, i));
            exp_q.push_back(ov(S_D, i));
        end
        exp_q.push_back(ov(S_IDLE, 0));
        exp_q.push_back(ov(S_IDLE, 0));
        start3 = 1'b1;
        run("s4_flush", 1, 1'b0);
        start3 = 1'b0;
        run("s4_flush", 5, 1'b0);
        flush3 = 1'b1;
        start3 = 1'b1;
        run("s4_flush_idle", 1, 1'b0);
        flush3 = 1'b0;
        start3 = 1'b0;
        run("s4_flush_idle", 1, 1'b0);
        push_divide(3);
        exp_q.push_back(ov(S_IDLE, 0));
        start3 = 1'b1;
        run("s4_restart", 1, 1'b0);
        start3 = 1'b0;
        run("s4_restart", 10, 1'b0);

        // Scenario 5: asynchronous reset mid K_STEP of it=1
        exp_q.push_back(ov(S_K, 0));
        exp_q.push_back(ov(S_N, 0));
        exp_q.push_back(ov(S_D, 0));
        exp_q.push_back(ov(S_K, 1));
        start3 = 1'b1;
        run("s5_pre", 1, 1'b0);
        start3 = 1'b0;
        run("s5_pre", 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(ov(S_IDLE, 0));
        compare("s5_async_zero", obs3);
        exp_q.push_back(ov(S_IDLE, 0));
        run("s5_held_zero", 1, 1'b0);
        rst_n = 1'b1;
        exp_q.push_back(ov(S_IDLE, 0));
        run("s5_release_idle", 1, 1'b0);
        push_divide(3);
        exp_q.push_back(ov(S_IDLE, 0));
        start3 = 1'b1;
        run("s5_restart", 1, 1'b0);
        start3 = 1'b0;
        run("s5_restart", 10, 1'b0);

        // Scenario 6: ITER=1 build, done in cycle 4, kSelect never 1
        push_divide(1);
        exp_q.push_back(ov(S_IDLE, 0));
        start1 = 1'b1;
        run("s6_iter1", 1, 1'b1);
        start1 = 1'b0;
        run("s6_iter1", 4, 1'b1);
        push_divide(1);
        push_divide(1);
        exp_q.push_back(ov(S_IDLE, 0));
        start1 = 1'b1;
        run("s6_iter1_b2b", 8, 1'b1);
        start1 = 1'b0;
        run("s6_iter1_b2b", 1, 1'b1);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
